// File: rtl/product_accumulator_pkg.sv
// Shared types and width helpers for the product accumulator slice.
// Imported by the top level; the FIFO is kept generic.
package product_accumulator_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StAccum
  } state_e;

  function automatic int unsigned prod_w(input int unsigned width);
    return 2 * width;
  endfunction

  function automatic int unsigned acc_w(input int unsigned width, input int unsigned guard);
    return 2 * width + guard;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// First-word fall-through result FIFO.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module result_fifo #(
  parameter int unsigned W     = 25,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [W-1:0]    r_mem [DEPTH];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [PtrW:0]   r_cnt;
  logic            w_pop_ok;
  logic            w_push_ok;

  assign o_empty   = (r_cnt == '0);
  assign o_full    = (r_cnt == (PtrW + 1)'(DEPTH));
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);
  assign o_data    = r_mem[r_rd_ptr];

  always_ff @(posedge clk_i) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push_ok && !w_pop_ok) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (!w_push_ok && w_pop_ok) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/product_accumulator.sv
// Sums a frame of signed products, rounds half-up and saturates, and queues
// the results for a valid/ready consumer.
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int unsigned WIDTH      = 24,
  parameter int unsigned GUARD      = 8,
  parameter int unsigned OUT_W      = 24,
  parameter int unsigned FRAC_SHIFT = 23,
  parameter int unsigned LEN_W      = 8,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    start_i,
  input  logic [LEN_W-1:0]        len_i,
  input  logic                    abort_i,
  input  logic                    valid_i,
  input  logic [2*WIDTH-1:0]      product_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic signed [OUT_W-1:0] out_data_o,
  output logic                    out_sat_o,
  output logic                    busy_o,
  output logic                    err_drop_o,
  output logic                    err_ovf_o,
  input  logic                    clr_err_i
);

  localparam int unsigned ProdW = prod_w(WIDTH);
  localparam int unsigned AccW  = acc_w(WIDTH, GUARD);
  localparam logic signed [AccW-1:0] RoundBias = AccW'(1) << (FRAC_SHIFT - 1);

  typedef struct packed {
    logic                    sat;
    logic signed [OUT_W-1:0] data;
  } result_t;

  state_e                 r_state, w_state_nxt;
  logic [LEN_W-1:0]       r_len;
  logic [LEN_W-1:0]       r_count;
  logic signed [AccW-1:0] r_acc;
  logic signed [AccW-1:0] r_sum;
  logic                   r_sum_vld;
  result_t                r_res;
  logic                   r_res_vld;
  logic                   r_err_drop;
  logic                   r_err_ovf;

  logic signed [AccW-1:0] w_prod_ext;
  logic                   w_take;
  logic                   w_last;
  logic                   w_new_start;
  logic                   w_load_len;
  logic signed [AccW-1:0] w_rnd;
  logic signed [AccW-1:0] w_shift;
  logic [AccW-OUT_W:0]    w_hi;
  logic                   w_sat;
  result_t                w_res;
  result_t                w_head;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_pop;

  assign w_prod_ext  = {{GUARD{product_i[ProdW-1]}}, product_i};
  assign w_take      = (r_state == StAccum) && valid_i && !abort_i;
  assign w_last      = w_take && (({1'b0, r_count} + (LEN_W + 1)'(1)) == {1'b0, r_len});
  assign w_new_start = start_i && (len_i != '0);
  assign w_load_len  = ((r_state == StIdle) && w_new_start) || (w_last && w_new_start);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_state <= StIdle;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (w_new_start) w_state_nxt = StAccum;
      StAccum: begin
        if (abort_i)                      w_state_nxt = StIdle;
        else if (w_last && !w_new_start)  w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    busy_o = 1'b0;
    if (r_state == StAccum) busy_o = 1'b1;
  end

  // acc/count are zero whenever the FSM is idle, so only ACCUM exits need clearing.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_len     <= '0;
      r_count   <= '0;
      r_acc     <= '0;
      r_sum     <= '0;
      r_sum_vld <= 1'b0;
    end else begin
      if (w_load_len) r_len <= len_i;
      if (w_take && !w_last) begin
        r_acc   <= r_acc + w_prod_ext;
        r_count <= r_count + 1'b1;
      end else if ((r_state == StAccum) && (abort_i || w_last)) begin
        r_acc   <= '0;
        r_count <= '0;
      end
      r_sum_vld <= w_last;
      if (w_last) r_sum <= r_acc + w_prod_ext;
    end
  end

  // Saturated when the bits above the output sign bit are not a pure sign extension.
  always_comb begin
    w_rnd      = r_sum + RoundBias;
    w_shift    = w_rnd >>> FRAC_SHIFT;
    w_hi       = w_shift[AccW-1:OUT_W-1];
    w_sat      = !((&w_hi) || !(|w_hi));
    w_res.sat  = w_sat;
    w_res.data = w_shift[OUT_W-1:0];
    if (w_sat) begin
      w_res.data = w_shift[AccW-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_res     <= '0;
      r_res_vld <= 1'b0;
    end else begin
      r_res_vld <= r_sum_vld;
      if (r_sum_vld) r_res <= w_res;
    end
  end

  result_fifo #(
    .W     ($bits(result_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .i_push  (r_res_vld),
    .i_data  (r_res),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign out_valid_o = !w_empty;
  assign w_pop       = out_valid_o && out_ready_i;
  assign out_data_o  = w_empty ? '0 : w_head.data;
  assign out_sat_o   = !w_empty && w_head.sat;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_err_drop <= 1'b0;
      r_err_ovf  <= 1'b0;
    end else begin
      r_err_drop <= (r_err_drop && !clr_err_i) || (valid_i && (r_state != StAccum));
      r_err_ovf  <= (r_err_ovf && !clr_err_i) || (r_res_vld && w_full && !w_pop);
    end
  end

  assign err_drop_o = r_err_drop;
  assign err_ovf_o  = r_err_ovf;

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench for product_accumulator at the small test configuration.
module tb_product_accumulator;

  logic              clk_i = 1'b0;
  logic              rstn_i;
  logic              start_i;
  logic [3:0]        len_i;
  logic              abort_i;
  logic              valid_i;
  logic [15:0]       product_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [7:0]        out_data_o;
  logic              out_sat_o;
  logic              busy_o;
  logic              err_drop_o;
  logic              err_ovf_o;
  logic              clr_err_i;

  int total = 0;
  int bad   = 0;
  logic [8:0] sb [$];
  logic [8:0] mon_exp;

  product_accumulator #(
    .WIDTH      (8),
    .GUARD      (4),
    .OUT_W      (8),
    .FRAC_SHIFT (7),
    .LEN_W      (4),
    .DEPTH      (4)
  ) dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .start_i     (start_i),
    .len_i       (len_i),
    .abort_i     (abort_i),
    .valid_i     (valid_i),
    .product_i   (product_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_sat_o   (out_sat_o),
    .busy_o      (busy_o),
    .err_drop_o  (err_drop_o),
    .err_ovf_o   (err_ovf_o),
    .clr_err_i   (clr_err_i)
  );

  always #5 clk_i = ~clk_i;

  // Independent model: half-up round by 2^7, clamp to signed 8 bits; {sat, data}.
  function automatic logic [8:0] model(input int sum);
    int r;
    r = (sum + 64) >>> 7;
    if (r > 127)  return {1'b1, 8'h7f};
    if (r < -128) return {1'b1, 8'h80};
    return {1'b0, r[7:0]};
  endfunction

  always @(negedge clk_i) begin
    if (rstn_i && out_valid_o && out_ready_i) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output got data=%0d sat=%0b required no output",
                 $signed(out_data_o), out_sat_o);
      end else begin
        mon_exp = sb.pop_front();
        if ({out_sat_o, out_data_o} !== mon_exp) begin
          bad++;
          $display("FAIL result got data=%0d sat=%0b required data=%0d sat=%0b",
                   $signed(out_data_o), out_sat_o, $signed(mon_exp[7:0]), mon_exp[8]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_start(input int len);
    start_i = 1'b1;
    len_i   = len[3:0];
    cyc();
    start_i = 1'b0;
  endtask

  task automatic drive_prod(input int p);
    valid_i   = 1'b1;
    product_i = p[15:0];
    cyc();
    valid_i   = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid_o) && n < 40) begin
      cyc();
      n++;
    end
    total++;
    if (n >= 40) begin
      bad++;
      $display("FAIL drain got pending=%0d required 0", sb.size());
    end
  endtask

  task automatic test_reset();
    rstn_i = 1'b0; start_i = 1'b0; len_i = '0; abort_i = 1'b0; valid_i = 1'b0;
    product_i = '0; out_ready_i = 1'b1; clr_err_i = 1'b0;
    #3;
    total++;
    if ({out_valid_o, out_data_o, out_sat_o, busy_o, err_drop_o, err_ovf_o} !== 13'd0) begin
      bad++;
      $display("FAIL reset_outputs got %b required 0",
               {out_valid_o, out_data_o, out_sat_o, busy_o, err_drop_o, err_ovf_o});
    end
    @(negedge clk_i);
    rstn_i = 1'b1;
    cyc();
    total++;
    if (out_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_release got valid=%b busy=%b required 0 0", out_valid_o, busy_o);
    end
  endtask

  task automatic test_basic();
    drive_start(3);
    total++;
    if (busy_o !== 1'b1) begin
      bad++; $display("FAIL basic_busy got %b required 1", busy_o);
    end
    drive_prod(128);
    drive_prod(128);
    sb.push_back(model(384));
    drive_prod(128);
    total++;
    if (busy_o !== 1'b0 || out_valid_o !== 1'b0) begin
      bad++; $display("FAIL basic_t0 got busy=%b valid=%b required 0 0", busy_o, out_valid_o);
    end
    cyc();
    total++;
    if (out_valid_o !== 1'b0) begin
      bad++; $display("FAIL basic_t1 got valid=%b required 0", out_valid_o);
    end
    cyc();
    total++;
    if (out_valid_o !== 1'b1 || out_data_o !== 8'd3) begin
      bad++; $display("FAIL basic_t2 got valid=%b data=%0d required 1 3", out_valid_o,
                      $signed(out_data_o));
    end
    drain();
  endtask

  task automatic test_round();
    int vals [3] = '{-64, -65, 192};
    foreach (vals[i]) begin
      drive_start(1);
      sb.push_back(model(vals[i]));
      drive_prod(vals[i]);
    end
    drain();
  endtask

  task automatic test_sat();
    int vals [2] = '{16384, -16384};
    foreach (vals[i]) begin
      drive_start(2);
      drive_prod(vals[i]);
      sb.push_back(model(2 * vals[i]));
      drive_prod(vals[i]);
    end
    drain();
  endtask

  task automatic test_ovf();
    out_ready_i = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      drive_start(1);
      if (k <= 4) sb.push_back(model(128 * k));
      drive_prod(128 * k);
    end
    repeat (4) cyc();
    total++;
    if (err_ovf_o !== 1'b1 || out_valid_o !== 1'b1 || out_data_o !== 8'd1) begin
      bad++; $display("FAIL ovf_full got ovf=%b valid=%b data=%0d required 1 1 1", err_ovf_o,
                      out_valid_o, $signed(out_data_o));
    end
    out_ready_i = 1'b1;
    drain();
    total++;
    if (err_ovf_o !== 1'b1) begin
      bad++; $display("FAIL ovf_sticky got %b required 1", err_ovf_o);
    end
    clr_err_i = 1'b1;
    cyc();
    clr_err_i = 1'b0;
    total++;
    if (err_ovf_o !== 1'b0) begin
      bad++; $display("FAIL ovf_clear got %b required 0", err_ovf_o);
    end
  endtask

  task automatic test_back_to_back();
    drive_start(2);
    drive_prod(256);
    sb.push_back(model(384));
    valid_i = 1'b1; product_i = 16'd128; start_i = 1'b1; len_i = 4'd1;
    cyc();
    start_i = 1'b0;
    total++;
    if (busy_o !== 1'b1) begin
      bad++; $display("FAIL b2b_busy got %b required 1", busy_o);
    end
    sb.push_back(model(-300));
    drive_prod(-300);
    total++;
    if (busy_o !== 1'b0 || err_drop_o !== 1'b0) begin
      bad++; $display("FAIL b2b_end got busy=%b drop=%b required 0 0", busy_o, err_drop_o);
    end
    drain();
    drive_prod(77);
    total++;
    if (err_drop_o !== 1'b1) begin
      bad++; $display("FAIL drop_set got %b required 1", err_drop_o);
    end
    clr_err_i = 1'b1;
    cyc();
    clr_err_i = 1'b0;
    repeat (3) cyc();
    total++;
    if (err_drop_o !== 1'b0 || out_valid_o !== 1'b0) begin
      bad++; $display("FAIL drop_clear got drop=%b valid=%b required 0 0", err_drop_o,
                      out_valid_o);
    end
  endtask

  task automatic test_abort();
    drive_start(3);
    drive_prod(1000);
    abort_i = 1'b1; valid_i = 1'b1; product_i = 16'd500;
    cyc();
    abort_i = 1'b0; valid_i = 1'b0;
    total++;
    if (busy_o !== 1'b0 || err_drop_o !== 1'b0) begin
      bad++; $display("FAIL abort_idle got busy=%b drop=%b required 0 0", busy_o, err_drop_o);
    end
    repeat (4) cyc();
    total++;
    if (out_valid_o !== 1'b0) begin
      bad++; $display("FAIL abort_noout got %b required 0", out_valid_o);
    end
    drive_start(1);
    sb.push_back(model(128));
    drive_prod(128);
    drain();
  endtask

  task automatic test_async_reset();
    out_ready_i = 1'b0;
    drive_start(1);
    drive_prod(128);
    drive_start(1);
    drive_prod(256);
    repeat (3) cyc();
    total++;
    if (out_valid_o !== 1'b1) begin
      bad++; $display("FAIL areset_fill got %b required 1", out_valid_o);
    end
    drive_start(2);
    drive_prod(1000);
    #2 rstn_i = 1'b0;
    #1;
    total++;
    if ({out_valid_o, out_data_o, out_sat_o, busy_o, err_drop_o, err_ovf_o} !== 13'd0) begin
      bad++;
      $display("FAIL areset_outputs got %b required 0",
               {out_valid_o, out_data_o, out_sat_o, busy_o, err_drop_o, err_ovf_o});
    end
    @(negedge clk_i);
    rstn_i = 1'b1;
    out_ready_i = 1'b1;
    cyc();
    total++;
    if (out_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++; $display("FAIL areset_after got valid=%b busy=%b required 0 0", out_valid_o, busy_o);
    end
    drive_start(1);
    sb.push_back(model(128));
    drive_prod(128);
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round();
    test_sat();
    test_ovf();
    test_back_to_back();
    test_abort();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
